// File: rtl/alu_op_issue.sv
// Issue stage for the ALU Operation port: decodes ALUOp/funct3/funct7 into a 4-bit
// ALU code and queues {op, tag, illegal} in a 2-entry FIFO with registered handshakes.
module alu_op_issue #(
  parameter int unsigned OPCODE_LENGTH = 4,
  parameter int unsigned TAG_WIDTH     = 5,
  parameter int unsigned ILL_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               ALUOp,
  input  logic [2:0]               funct3,
  input  logic [6:0]               funct7,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [TAG_WIDTH-1:0]     out_tag,
  output logic                     out_illegal,
  input  logic                     ill_clear,
  output logic [ILL_CNT_WIDTH-1:0] ill_count
);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0101);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b0111);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b1010);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT = OPCODE_LENGTH'(4'b1100);
  localparam logic [OPCODE_LENGTH-1:0] OP_ILL = OPCODE_LENGTH'(4'b1111);

  typedef struct packed {
    logic [OPCODE_LENGTH-1:0] op;
    logic [TAG_WIDTH-1:0]     tag;
    logic                     illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t state, state_d;
  entry_t head, head_d, tail, tail_d, new_entry;
  logic [OPCODE_LENGTH-1:0] dec_op;
  logic dec_ill, push, pop, i_type, f7_zero, f7_alt;

  assign i_type  = ALUOp[0];
  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);

  // Translation; the illegal code 1111 is never produced by a legal encoding.
  always_comb begin
    dec_op = OP_ILL;
    case (ALUOp)
      2'b00: dec_op = OP_ADD;
      2'b01: begin
        case (funct3)
          3'b000, 3'b001: dec_op = OP_EQ;
          3'b100:         dec_op = OP_SLT;
          default:        dec_op = OP_ILL;
        endcase
      end
      default: begin
        // I-type ignores funct7 for the logic/compare ops and for ADD.
        case (funct3)
          3'b000: begin
            if (i_type || f7_zero) dec_op = OP_ADD;
            else if (f7_alt)       dec_op = OP_SUB;
          end
          3'b111: if (i_type || f7_zero) dec_op = OP_AND;
          3'b110: if (i_type || f7_zero) dec_op = OP_OR;
          3'b100: if (i_type || f7_zero) dec_op = OP_XOR;
          3'b010: if (i_type || f7_zero) dec_op = OP_SLT;
          3'b001: if (f7_zero)           dec_op = OP_SLL;
          3'b101: if (f7_alt)            dec_op = OP_SRA;
          default: dec_op = OP_ILL;
        endcase
      end
    endcase
  end

  assign dec_ill   = (dec_op == OP_ILL);
  assign new_entry = '{op: dec_op, tag: in_tag, illegal: dec_ill};
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_d;
  end

  // Next state and FIFO register updates; head is always the oldest entry.
  always_comb begin
    state_d = state;
    head_d  = head;
    tail_d  = tail;
    case (state)
      EMPTY: begin
        if (push) begin
          head_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          tail_d  = new_entry;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d  = tail;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Handshake flags are registered from the next state, so in_ready never sees out_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      head      <= head_d;
      tail      <= tail_d;
      in_ready  <= (state_d != FULL);
      out_valid <= (state_d != EMPTY);
    end
  end

  assign Operation   = head.op;
  assign out_tag     = head.tag;
  assign out_illegal = head.illegal;

  // Saturating illegal counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ill_count <= '0;
    end else if (ill_clear) begin
      ill_count <= '0;
    end else if (push && dec_ill && (ill_count != '1)) begin
      ill_count <= ill_count + ILL_CNT_WIDTH'(1);
    end
  end

endmodule
